vector_mem_unit: RTL and testbench

- Multi-cycle vector load/store sequencer between the 5-lane vector register file and the single-ported 32-bit data memory.
- Serialises a 5-lane vector into word accesses at consecutive addresses. A store writes the lanes out one word per cycle. A load collects the lanes from memory and presents them as one vector write-back.
- Raises busy so the control unit stalls the PC and scalar datapath while the transfer runs.

---
 rtl/vector_mem_unit.sv | 137 +++++++++++++
 tb/tb_vector_mem_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_unit.sv
// Vector load/store sequencer: moves a 5-lane vector to or from single-ported data memory,
// one 32-bit word per cycle at consecutive word addresses, then reports completion.
module vector_mem_unit #(
    parameter int LANES  = 5,
    parameter int WIDTH  = 32,
    parameter int STRIDE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_load,
    input  logic [31:0]      base_addr,
    input  logic [WIDTH-1:0] vec_in_0,
    input  logic [WIDTH-1:0] vec_in_1,
    input  logic [WIDTH-1:0] vec_in_2,
    input  logic [WIDTH-1:0] vec_in_3,
    input  logic [WIDTH-1:0] vec_in_4,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic             busy,
    output logic             done,
    output logic             vec_we,
    output logic [WIDTH-1:0] vec_out_0,
    output logic [WIDTH-1:0] vec_out_1,
    output logic [WIDTH-1:0] vec_out_2,
    output logic [WIDTH-1:0] vec_out_3,
    output logic [WIDTH-1:0] vec_out_4,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_is_load;
    logic [31:0]      r_addr;
    logic [WIDTH-1:0] r_snap [LANES];
    logic [WIDTH-1:0] r_lane [LANES];
    logic [WIDTH-1:0] w_vec_in [LANES];
    logic             w_last;

    assign w_vec_in[0] = vec_in_0;
    assign w_vec_in[1] = vec_in_1;
    assign w_vec_in[2] = vec_in_2;
    assign w_vec_in[3] = vec_in_3;
    assign w_vec_in[4] = vec_in_4;

    assign w_last = (r_idx == IDX_W'(LANES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_XFER;
            S_XFER:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // All memory-side outputs decode from registered state only, so start never reaches them.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        done      = 1'b0;
        vec_we    = 1'b0;
        case (r_state)
            S_XFER: begin
                mem_addr = r_addr;
                if (!r_is_load) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_snap[r_idx];
                end
            end
            S_DONE: begin
                done   = 1'b1;
                vec_we = r_is_load;
            end
            default: ;
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

    assign vec_out_0 = r_lane[0];
    assign vec_out_1 = r_lane[1];
    assign vec_out_2 = r_lane[2];
    assign vec_out_3 = r_lane[3];
    assign vec_out_4 = r_lane[4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_is_load <= 1'b0;
            r_addr    <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_snap[i] <= '0;
                r_lane[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_load <= is_load;
                        r_addr    <= {base_addr[31:2], 2'b00};
                        r_idx     <= '0;
                        for (int i = 0; i < LANES; i++) begin
                            r_snap[i] <= w_vec_in[i];
                        end
                    end
                end
                S_XFER: begin
                    if (r_is_load) begin
                        r_lane[r_idx] <= mem_rdata;
                    end
                    // Address wraps modulo 2^32 by plain overflow.
                    r_addr <= r_addr + 32'(STRIDE);
                    r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed bench for vector_mem_unit: store, load, wrap, ignored start, async reset
// mid-transfer and back-to-back operations, each cycle checked against hand-computed values.
module tb_vector_mem_unit;

    typedef logic [4:0][31:0] vec5_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_load;
    logic [31:0] base_addr;
    logic [31:0] vec_in_0, vec_in_1, vec_in_2, vec_in_3, vec_in_4;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        vec_we;
    logic [31:0] vec_out_0, vec_out_1, vec_out_2, vec_out_3, vec_out_4;
    logic [1:0]  dbg_state;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    int          n_vec;
    int          n_err;

    vector_mem_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_load   (is_load),
        .base_addr (base_addr),
        .vec_in_0  (vec_in_0),
        .vec_in_1  (vec_in_1),
        .vec_in_2  (vec_in_2),
        .vec_in_3  (vec_in_3),
        .vec_in_4  (vec_in_4),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .vec_we    (vec_we),
        .vec_out_0 (vec_out_0),
        .vec_out_1 (vec_out_1),
        .vec_out_2 (vec_out_2),
        .vec_out_3 (vec_out_3),
        .vec_out_4 (vec_out_4),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec5_t mk5(input logic [31:0] a, b, c, d, e);
        vec5_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
        return r;
    endfunction

    task automatic drive_vec(input vec5_t v);
        vec_in_0 = v[0]; vec_in_1 = v[1]; vec_in_2 = v[2]; vec_in_3 = v[3]; vec_in_4 = v[4];
    endtask

    task automatic check_vout(input string tag, input vec5_t v);
        check({tag, "_vout0"}, vec_out_0, v[0]);
        check({tag, "_vout1"}, vec_out_1, v[1]);
        check({tag, "_vout2"}, vec_out_2, v[2]);
        check({tag, "_vout3"}, vec_out_3, v[3]);
        check({tag, "_vout4"}, vec_out_4, v[4]);
    endtask

    // Full operation; expected data is wdata for stores and vec_out for loads.
    task automatic run_op(input string tag, input logic ld, input logic [31:0] base,
                          input vec5_t vin, input vec5_t exp_addr, input vec5_t exp_data,
                          input int pulse_cycle);
        @(negedge clk);
        start = 1'b1; is_load = ld; base_addr = base; drive_vec(vin);
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_addr[i]);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_we"}, mem_we, !ld);
            check({tag, "_addr"}, mem_addr, exp_q.pop_front());
            if (!ld) check({tag, "_wdata"}, mem_wdata, exp_data[c-1]);
            check({tag, "_done_x"}, done, 1'b0);
            // Disturb inputs after acceptance; optional ignored start pulse.
            base_addr = 32'h0000_0300; is_load = !ld;
            drive_vec(mk5(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004));
            start = (c == pulse_cycle);
        end
        @(negedge clk);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_vecwe"}, vec_we, ld);
        check({tag, "_busy6"}, busy, 1'b1);
        check({tag, "_we6"}, mem_we, 1'b0);
        check({tag, "_state6"}, dbg_state, 32'd2);
        if (ld) check_vout({tag, "_c6"}, exp_data);
        @(negedge clk);
        check({tag, "_busy7"}, busy, 1'b0);
        check({tag, "_done7"}, done, 1'b0);
        check({tag, "_vecwe7"}, vec_we, 1'b0);
        check({tag, "_addr7"}, mem_addr, 32'h0);
        if (ld) check_vout({tag, "_c7"}, exp_data);
        @(negedge clk);
        check({tag, "_busy8"}, busy, 1'b0);
        check({tag, "_we8"}, mem_we, 1'b0);
    endtask

    vec5_t load_exp;

    initial begin
        n_vec = 0; n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 5; i++) mem[64 + i] = 32'hA0 + 32'(i);
        load_exp = mk5(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);

        // Reset state, with start asserted alongside reset.
        reset = 1'b1; start = 1'b1; is_load = 1'b0; base_addr = 32'h40;
        drive_vec(mk5(1, 2, 3, 4, 5));
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_vecwe", vec_we, 1'b0);
        check("rst_state", dbg_state, 32'd0);
        check_vout("rst", mk5(0, 0, 0, 0, 0));
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", busy, 1'b0);

        run_op("store", 1'b0, 32'h40, mk5(1, 2, 3, 4, 5),
               mk5(32'h40, 32'h44, 32'h48, 32'h4C, 32'h50), mk5(1, 2, 3, 4, 5), 0);

        run_op("load", 1'b1, 32'h100, mk5(9, 9, 9, 9, 9),
               mk5(32'h100, 32'h104, 32'h108, 32'h10C, 32'h110), load_exp, 0);

        run_op("wrap", 1'b0, 32'hFFFF_FFF7, mk5(32'h11, 32'h22, 32'h33, 32'h44, 32'h55),
               mk5(32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4),
               mk5(32'h11, 32'h22, 32'h33, 32'h44, 32'h55), 0);

        run_op("ignstart", 1'b0, 32'h80, mk5(32'h61, 32'h62, 32'h63, 32'h64, 32'h65),
               mk5(32'h80, 32'h84, 32'h88, 32'h8C, 32'h90),
               mk5(32'h61, 32'h62, 32'h63, 32'h64, 32'h65), 3);

        // Asynchronous reset during a load, between edges 3 and 4.
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; base_addr = 32'h100; drive_vec(mk5(0, 0, 0, 0, 0));
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy_pre", busy, 1'b1);
        check("mid_addr_pre", mem_addr, 32'h10C);
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_we", mem_we, 1'b0);
        check("mid_addr", mem_addr, 32'h0);
        check("mid_state", dbg_state, 32'd0);
        check_vout("mid", mk5(0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("post_rst_done", done, 1'b0);
            check("post_rst_vecwe", vec_we, 1'b0);
            check("post_rst_busy", busy, 1'b0);
        end
        run_op("fresh", 1'b0, 32'h200, mk5(32'h11, 32'h12, 32'h13, 32'h14, 32'h15),
               mk5(32'h200, 32'h204, 32'h208, 32'h20C, 32'h210),
               mk5(32'h11, 32'h12, 32'h13, 32'h14, 32'h15), 0);

        // Back-to-back: store, then a load request held high from cycle 1.
        @(negedge clk);
        start = 1'b1; is_load = 1'b0; base_addr = 32'h40; drive_vec(mk5(7, 8, 9, 10, 11));
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) begin
                is_load = 1'b1; base_addr = 32'h100;
            end
            if (c == 5) check("b2b_st_addr5", mem_addr, 32'h50);
            if (c == 6) check("b2b_st_done", done, 1'b1);
            if (c == 7) begin
                check("b2b_busy7", busy, 1'b0);
                check("b2b_addr7", mem_addr, 32'h0);
            end
            if (c == 8) begin
                check("b2b_busy8", busy, 1'b1);
                check("b2b_addr8", mem_addr, 32'h100);
                check("b2b_we8", mem_we, 1'b0);
                start = 1'b0;
            end
            if (c == 12) check("b2b_done12", done, 1'b0);
            if (c == 13) begin
                check("b2b_done13", done, 1'b1);
                check("b2b_vecwe13", vec_we, 1'b1);
                check_vout("b2b", load_exp);
            end
        end
        @(negedge clk);
        check("b2b_busy14", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
